operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read-side companion of the GPR register file; sits between decode and execute.
- Accepts instruction operand requests, drives the register file read ports, and bypasses the writeback being committed this cycle.
- Tracks in-flight destination registers with a scoreboard and stalls on hazards.
- Delivers registered operands to execute over a valid/ready handshake.

Parameters:
DATA_W, 32, operand/register data width
ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  decode presents a request
req_ready  out  1  request accepted this cycle when req_valid && req_ready
req_a_addr  in  ADDR_W  source A register
req_b_addr  in  ADDR_W  source B register
req_dest  in  ADDR_W  destination register
req_we  in  1  instruction will write req_dest
rf_a_addr  out  ADDR_W  register file A read address
rf_b_addr  out  ADDR_W  register file B read address
rf_a_data  in  DATA_W  register file A read data (combinational)
rf_b_data  in  DATA_W  register file B read data (combinational)
wb_valid  in  1  writeback to register file this cycle (same signal as register file rw)
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback data
op_valid  out  1  operand bundle valid
op_ready  in  1  execute consumes bundle
op_a  out  DATA_W  operand A
op_b  out  DATA_W  operand B
op_dest  out  ADDR_W  destination
op_we  out  1  write-enable passthrough

Behaviour:
- Read ports: rf_a_addr = req_a_addr, rf_b_addr = req_b_addr; combinational and driven regardless of req_valid.
- Bypass: byp_x = wb_valid && wb_addr == req_x_addr. When set, the operand comes from wb_data; otherwise from rf_x_data.
  - Bypass applies even when the register is not pending, because the register file write lands only at the clock edge.
- Scoreboard: pending[2**ADDR_W] bit vector.
  - Set pending[req_dest] on accept with req_we=1.
  - Clear pending[wb_addr] when wb_valid=1.
  - Set and clear of the same register in the same cycle: set wins.
  - wb_valid to a non-pending register: clear is a no-op; no error.
- Hazard (combinational), asserted if any of:
  - RAW on A: pending[req_a_addr] && !byp_a.
  - RAW on B: pending[req_b_addr] && !byp_b.
  - WAW: req_we && pending[req_dest] && !(wb_valid && wb_addr == req_dest).
- No register is hardwired to zero; register 0 is scoreboarded like any other.
- req_ready = !hazard && (!op_valid || op_ready). It may depend on request fields; it must not depend on req_valid.
- Output stage, two-state FSM:
  - EMPTY (op_valid=0): on accept go to FULL.
  - FULL (op_valid=1): if op_ready and accept, stay FULL and load the new bundle; if op_ready and no accept, go to EMPTY; if !op_ready, hold.
- Latency: 1 cycle from accept edge to op_valid=1.
- op_a, op_b, op_dest, op_we are loaded only on accept. They are stable while op_valid && !op_ready.
- Throughput: one request per cycle when hazard-free and execute is not stalled.
- Reset (rst_n=0, asynchronous, immediate): pending = 0, FSM = EMPTY, op_valid = 0, op_a = 0, op_b = 0, op_dest = 0, op_we = 0.
- Reset mid-operation discards the held bundle and all pending bits. Writebacks arriving after reset are harmless no-ops.
- req_a_addr == req_b_addr: both operands take identical values; the hazard is evaluated once.
- req_dest equal to a source: the source is read before pending is set; no self-stall.

Test Plan:
1. Reset; req a=1, b=2, we=0, rf_a_data=0x11, rf_b_data=0x22, op_ready=1 -> req_ready=1, next cycle op_valid=1, op_a=0x11, op_b=0x22.
2. Accept dest=5, we=1; next req a=5 -> req_ready=0 for 3 cycles. Then wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF -> req_ready=1 that cycle; op_a=0xDEADBEEF next cycle; pending[5]=0.
3. Pending empty; req b=7 while wb_valid=1, wb_addr=7, wb_data=0xCAFEF00D, rf_b_data=0x0 -> op_b=0xCAFEF00D.
4. op_ready=0 with bundle held (op_a=0x11) -> op_valid stays 1, op_a stable, req_ready=0. Raise op_ready -> queued request accepted in that same cycle, new bundle the next cycle.
5. WAW: accept dest=3, we=1; next req dest=3, we=1 -> stall. wb_valid for addr 3 -> accept, pending[3] remains 1 (set wins).
6. Accept dest=9, we=1, then pull rst_n low mid-cycle -> op_valid=0 immediately. After release, req a=9 is accepted with no stall.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage between decode and execute: reads the GPR file, bypasses
// the writeback in flight, scoreboards pending destinations and stalls on hazards.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [ADDR_W-1:0] req_dest,
  input  logic              req_we,
  output logic [ADDR_W-1:0] rf_a_addr,
  output logic [ADDR_W-1:0] rf_b_addr,
  input  logic [DATA_W-1:0] rf_a_data,
  input  logic [DATA_W-1:0] rf_b_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_dest,
  output logic              op_we
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_next;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [ADDR_W-1:0] r_op_dest;
  logic              r_op_we;

  logic              w_byp_a;
  logic              w_byp_b;
  logic              w_byp_dest;
  logic              w_raw_a;
  logic              w_raw_b;
  logic              w_waw;
  logic              w_hazard;
  logic              w_out_free;
  logic              w_accept;
  logic [DATA_W-1:0] w_src_a;
  logic [DATA_W-1:0] w_src_b;

  assign rf_a_addr = req_a_addr;
  assign rf_b_addr = req_b_addr;

  // The register file only updates at the edge, so a same-cycle writeback must
  // be forwarded whether or not the register was scoreboarded.
  assign w_byp_a    = wb_valid && (wb_addr == req_a_addr);
  assign w_byp_b    = wb_valid && (wb_addr == req_b_addr);
  assign w_byp_dest = wb_valid && (wb_addr == req_dest);

  assign w_src_a = w_byp_a ? wb_data : rf_a_data;
  assign w_src_b = w_byp_b ? wb_data : rf_b_data;

  assign w_raw_a  = r_pending[req_a_addr] && !w_byp_a;
  assign w_raw_b  = r_pending[req_b_addr] && !w_byp_b;
  assign w_waw    = req_we && r_pending[req_dest] && !w_byp_dest;
  assign w_hazard = w_raw_a || w_raw_b || w_waw;

  assign op_valid   = (r_state == ST_FULL);
  assign w_out_free = !op_valid || op_ready;
  assign req_ready  = !w_hazard && w_out_free;
  assign w_accept   = req_valid && req_ready;

  // Clear first, then set, so a new claim beats a retiring writeback.
  always_comb begin
    w_pending_next = r_pending;
    if (wb_valid) begin
      w_pending_next[wb_addr] = 1'b0;
    end
    if (w_accept && req_we) begin
      w_pending_next[req_dest] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (op_ready && !w_accept) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  // Bundle registers change only on accept, which keeps them stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_dest <= '0;
      r_op_we   <= 1'b0;
    end else if (w_accept) begin
      r_op_a    <= w_src_a;
      r_op_b    <= w_src_b;
      r_op_dest <= req_dest;
      r_op_we   <= req_we;
    end
  end

  assign op_a    = r_op_a;
  assign op_b    = r_op_b;
  assign op_dest = r_op_dest;
  assign op_we   = r_op_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch: reset, bypass, scoreboard
// hazards, backpressure, back-to-back throughput and mid-run reset.
module tb_operand_fetch;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_a_addr;
  logic [ADDR_W-1:0] req_b_addr;
  logic [ADDR_W-1:0] req_dest;
  logic              req_we;
  logic [ADDR_W-1:0] rf_a_addr;
  logic [ADDR_W-1:0] rf_b_addr;
  logic [DATA_W-1:0] rf_a_data;
  logic [DATA_W-1:0] rf_b_data;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [ADDR_W-1:0] op_dest;
  logic              op_we;

  int n_vec;
  int n_err;

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a_addr (req_a_addr),
    .req_b_addr (req_b_addr),
    .req_dest   (req_dest),
    .req_we     (req_we),
    .rf_a_addr  (rf_a_addr),
    .rf_b_addr  (rf_b_addr),
    .rf_a_data  (rf_a_data),
    .rf_b_data  (rf_b_data),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_dest    (op_dest),
    .op_we      (op_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_a_addr = '0;
    req_b_addr = '0;
    req_dest   = '0;
    req_we     = 1'b0;
    rf_a_data  = '0;
    rf_b_data  = '0;
    wb_valid   = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    op_ready   = 1'b1;
  endtask

  task automatic set_req(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] d, input logic we,
                         input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db);
    req_valid  = 1'b1;
    req_a_addr = a;
    req_b_addr = b;
    req_dest   = d;
    req_we     = we;
    rf_a_data  = da;
    rf_b_data  = db;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL reset_op_valid got=%b exp=0", op_valid); end
    n_vec++; if (op_a !== '0) begin n_err++; $display("FAIL reset_op_a got=%h exp=0", op_a); end
    n_vec++; if (op_b !== '0) begin n_err++; $display("FAIL reset_op_b got=%h exp=0", op_b); end
    n_vec++; if ({op_dest, op_we} !== '0) begin n_err++; $display("FAIL reset_dest_we got=%h/%b exp=0/0", op_dest, op_we); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    $display("reset: op_valid=%b req_ready=%b", op_valid, req_ready);
    #19 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_req(5'd1, 5'd2, 5'd0, 1'b0, 32'h11, 32'h22);
    #1;
    n_vec++; if ({rf_a_addr, rf_b_addr} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL basic_rf_addr got=%0d/%0d exp=1/2", rf_a_addr, rf_b_addr); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got=%b exp=1", req_ready); end
    tick();
    idle();
    n_vec++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL basic_op_valid got=%b exp=1", op_valid); end
    n_vec++; if ({op_a, op_b} !== {32'h11, 32'h22}) begin n_err++; $display("FAIL basic_ops got=%h/%h exp=11/22", op_a, op_b); end
    $display("basic: op_a=%h op_b=%h", op_a, op_b);
    tick();
    n_vec++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got=%b exp=0", op_valid); end
  endtask

  task automatic test_raw();
    set_req(5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
    tick();
    set_req(5'd5, 5'd0, 5'd0, 1'b0, 32'h55, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall%0d got=%b exp=0", i, req_ready); end
      tick();
    end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL raw_release got=%b exp=1", req_ready); end
    tick();
    idle();
    n_vec++; if ({op_valid, op_a} !== {1'b1, 32'hDEADBEEF}) begin n_err++; $display("FAIL raw_bypass got=%b/%h exp=1/deadbeef", op_valid, op_a); end
    req_a_addr = 5'd5;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL raw_cleared got=%b exp=1", req_ready); end
    $display("raw: op_a=%h", op_a);
    idle();
    tick();
  endtask

  task automatic test_bypass();
    set_req(5'd0, 5'd7, 5'd0, 1'b0, 32'hA0, 32'h0);
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFEF00D;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL byp_ready got=%b exp=1", req_ready); end
    tick();
    set_req(5'd12, 5'd12, 5'd0, 1'b0, 32'h1, 32'h1);
    wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h77;
    n_vec++; if ({op_a, op_b} !== {32'hA0, 32'hCAFEF00D}) begin n_err++; $display("FAIL byp_b got=%h/%h exp=a0/cafef00d", op_a, op_b); end
    tick();
    idle();
    n_vec++; if ({op_a, op_b} !== {32'h77, 32'h77}) begin n_err++; $display("FAIL byp_same got=%h/%h exp=77/77", op_a, op_b); end
    $display("bypass: op_a=%h op_b=%h", op_a, op_b);
    tick();
  endtask

  task automatic test_backpressure();
    set_req(5'd1, 5'd2, 5'd4, 1'b0, 32'h11, 32'h22);
    tick();
    op_ready = 1'b0;
    set_req(5'd2, 5'd3, 5'd8, 1'b0, 32'h33, 32'h44);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if ({op_valid, op_a, req_ready} !== {1'b1, 32'h11, 1'b0})
        begin n_err++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/11/0", i, op_valid, op_a, req_ready); end
      tick();
    end
    op_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b exp=1", req_ready); end
    tick();
    idle();
    n_vec++; if ({op_valid, op_a, op_b, op_dest} !== {1'b1, 32'h33, 32'h44, 5'd8})
      begin n_err++; $display("FAIL bp_new got=%b/%h/%h/%0d exp=1/33/44/8", op_valid, op_a, op_b, op_dest); end
    $display("backpressure: op_a=%h op_b=%h", op_a, op_b);
    tick();
  endtask

  task automatic test_waw();
    set_req(5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
    tick();
    set_req(5'd1, 5'd2, 5'd3, 1'b1, 32'h5, 32'h6);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall%0d got=%b exp=0", i, req_ready); end
      tick();
    end
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL waw_release got=%b exp=1", req_ready); end
    tick();
    idle();
    n_vec++; if ({op_dest, op_we, op_a} !== {5'd3, 1'b1, 32'h5}) begin n_err++; $display("FAIL waw_bundle got=%0d/%b/%h exp=3/1/5", op_dest, op_we, op_a); end
    req_a_addr = 5'd3;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL waw_set_wins got=%b exp=0", req_ready); end
    wb_valid = 1'b1; wb_addr = 5'd3;
    tick();
    wb_valid = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL waw_cleared got=%b exp=1", req_ready); end
    $display("waw: op_dest=%0d op_we=%b", op_dest, op_we);
    idle();
    tick();
  endtask

  task automatic test_self_dest();
    set_req(5'd0, 5'd0, 5'd0, 1'b1, 32'h3C, 32'h3C);
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL self_ready got=%b exp=1", req_ready); end
    tick();
    set_req(5'd0, 5'd1, 5'd2, 1'b0, 32'h0, 32'h0);
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL r0_pending got=%b exp=0", req_ready); end
    $display("self_dest: op_a=%h ready=%b", op_a, req_ready);
    idle();
    wb_valid = 1'b1; wb_addr = 5'd0;
    tick();
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_req(5'(i + 16), 5'(i + 20), 5'(i + 24), 1'b0, 32'h100 + 32'(i), 32'h200 + 32'(i));
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got=%b exp=1", i, req_ready); end
      tick();
      n_vec++; if ({op_valid, op_a, op_b} !== {1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i)})
        begin n_err++; $display("FAIL b2b_op%0d got=%b/%h/%h exp=1/%h/%h", i, op_valid, op_a, op_b, 32'h100 + 32'(i), 32'h200 + 32'(i)); end
      $display("b2b %0d: op_a=%h op_b=%h", i, op_a, op_b);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(5'd1, 5'd2, 5'd9, 1'b1, 32'h12, 32'h34);
    tick();
    idle();
    op_ready = 1'b0;
    n_vec++; if (op_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre got=%b exp=1", op_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({op_valid, op_a, op_we} !== {1'b0, 32'h0, 1'b0}) begin n_err++; $display("FAIL rst_async got=%b/%h/%b exp=0/0/0", op_valid, op_a, op_we); end
    tick();
    rst_n = 1'b1;
    op_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1;
    tick();
    idle();
    set_req(5'd9, 5'd9, 5'd1, 1'b0, 32'h9, 32'h9);
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_no_stall got=%b exp=1", req_ready); end
    tick();
    idle();
    n_vec++; if ({op_valid, op_a} !== {1'b1, 32'h9}) begin n_err++; $display("FAIL rst_after got=%b/%h exp=1/9", op_valid, op_a); end
    $display("reset_mid: op_valid=%b op_a=%h", op_valid, op_a);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_raw();
    test_bypass();
    test_backpressure();
    test_waw();
    test_self_dest();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
